// File: rtl/seg_display_pkg.sv
// Shared types and segment constants for the two-digit seven-segment driver.
// Segment vectors are active-low, bit order {g,f,e,d,c,b,a}.
package seg_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_DONE
  } conv_state_e;

  localparam int BCD_ITERS = 7;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble iteration on {tens, ones, binary}: adjust nibbles, then shift.
  function automatic logic [14:0] dabble_step(input logic [14:0] s);
    logic [14:0] t;
    t = {dabble_adj(s[14:11]), dabble_adj(s[10:7]), s[6:0]};
    return {t[13:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// Load/status/display bundle of the seven-segment driver; master drives value strobes.
interface seg_display_driver_if;
  logic [6:0] value;
  logic       value_valid;
  logic       busy;
  logic       overrange;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (
    output value, value_valid,
    input  busy, overrange, seg, an
  );

  modport slave (
    input  value, value_valid,
    output busy, overrange, seg, an
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 7-bit binary to two-digit BCD converter (double dabble), 8 cycles busy.
// Strobes are only accepted in IDLE; anything arriving while busy is dropped.
module bin2bcd_seq
  import seg_display_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] value,
  input  logic       value_valid,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic       ovr
);

  conv_state_e state_q;
  logic [14:0] sr_q;
  logic [2:0]  iter_q;
  logic        busy_q;
  logic        done_q;
  logic        ovr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (value_valid) begin
            sr_q    <= {8'h00, value};
            iter_q  <= '0;
            busy_q  <= 1'b1;
            ovr_q   <= (value > 7'd99);
            state_q <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          sr_q   <= dabble_step(sr_q);
          iter_q <= iter_q + 3'd1;
          if (iter_q == 3'(BCD_ITERS - 1)) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Only meaningful while done is high; the top latches them on that edge.
  assign tens = sr_q[14:11];
  assign ones = sr_q[10:7];
  assign busy = busy_q;
  assign done = done_q;
  assign ovr  = ovr_q;

endmodule

// File: rtl/seg_display_driver.sv
// Two-digit multiplexed seven-segment driver: value strobe -> BCD -> display registers -> scan.
// Display updates 8 cycles after an accepted strobe; SEG_DISPLAY_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module seg_display_driver
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_display_driver_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [3:0]       conv_tens;
  logic [3:0]       conv_ones;
  logic             conv_busy;
  logic             conv_done;
  logic             conv_ovr;

  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             digit_q, digit_d;
  logic [6:0]       seg_q, seg_d;

  bin2bcd_seq u_bin2bcd (
    .clk         (clk),
    .reset       (reset),
    .value       (bus.value),
    .value_valid (bus.value_valid),
    .tens        (conv_tens),
    .ones        (conv_ones),
    .busy        (conv_busy),
    .done        (conv_done),
    .ovr         (conv_ovr)
  );

  function automatic logic [6:0] slot_seg(input logic dig, input logic [3:0] t,
                                          input logic [3:0] o, input logic ov);
    logic [6:0] s;
    if (ov) begin
      s = SEG_DASH;
    end else if (dig) begin
`ifdef SEG_DISPLAY_LEADING_ZERO_BLANK_EN
      s = (t == 4'd0) ? SEG_BLANK : seg_decode(t);
`else
      s = seg_decode(t);
`endif
    end else begin
      s = seg_decode(o);
    end
    return s;
  endfunction

  always_comb begin
    tens_d  = tens_q;
    ones_d  = ones_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q + CNT_W'(1);
    digit_d = digit_q;
    if (conv_done) begin
      tens_d = conv_tens;
      ones_d = conv_ones;
      ovr_d  = conv_ovr;
    end
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d   = '0;
      digit_d = ~digit_q;
    end
    // Decode from next-state values so seg and an switch on the same edge.
    seg_d = slot_seg(digit_d, tens_d, ones_d, ovr_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tens_q  <= '0;
      ones_q  <= '0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
      digit_q <= 1'b0;
      seg_q   <= SEG_0;
    end else begin
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.busy      = conv_busy;
  assign bus.overrange = ovr_q;
  assign bus.seg       = seg_q;
  assign bus.an        = digit_q ? 2'b01 : 2'b10;

endmodule

// File: tb/tb_seg_display_driver.sv
// Randomized bench for seg_display_driver against a decimal/cycle-count reference model.
module tb_seg_display_driver;

  localparam int DIV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_display_driver_if bus ();

  seg_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: edges since reset, cycles left in the conversion, shown value.
  int k      = 0;
  int rem    = 0;
  int pend   = 0;
  int disp_v = 0;

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg();
    int digit;
    int t;
    digit = (k / DIV) % 2;
    t = disp_v / 10;
    if (disp_v > 99) return 7'b0111111;
    if (digit == 1) begin
`ifdef SEG_DISPLAY_LEADING_ZERO_BLANK_EN
      if (t == 0) return 7'b1111111;
`endif
      return pat[t];
    end
    return pat[disp_v % 10];
  endfunction

  function automatic logic [1:0] exp_an();
    return (((k / DIV) % 2) == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic check_all();
    check_eq("busy", {31'd0, bus.busy}, (rem > 0) ? 32'd1 : 32'd0);
    check_eq("overrange", {31'd0, bus.overrange}, (disp_v > 99) ? 32'd1 : 32'd0);
    check_eq("an", {30'd0, bus.an}, {30'd0, exp_an()});
    check_eq("seg", {25'd0, bus.seg}, {25'd0, exp_seg()});
  endtask

  task automatic model_edge(input logic vv, input int v);
    k++;
    if (rem > 0) begin
      rem--;
      if (rem == 0) disp_v = pend;
    end else if (vv) begin
      pend = v;
      rem  = 8;
    end
  endtask

  // Called at a negedge: drive inputs, model the next rising edge, then check.
  task automatic cycle(input logic vv, input logic [6:0] v);
    bus.value       = v;
    bus.value_valid = vv;
    @(posedge clk);
    model_edge(vv, int'(v));
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 7'($urandom_range(0, 127)));
  endtask

  task automatic strobe(input logic [6:0] v);
    cycle(1'b1, v);
  endtask

  task automatic apply_reset();
    bus.value_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    k = 0;
    rem = 0;
    disp_v = 0;
    check_all();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.value       = '0;
    bus.value_valid = 1'b0;
    @(negedge clk);
    apply_reset();

    idle(3 * DIV);

    strobe(7'd57);
    idle(12);

    strobe(7'd99);
    idle(1);
    strobe(7'd10);
    idle(12);

    strobe(7'd120);
    idle(12);
    strobe(7'd3);
    idle(12);

    strobe(7'd42);
    idle(3);
    apply_reset();
    idle(2 * DIV);

    strobe(7'd7);
    idle(2 * DIV + 8);
    strobe(7'd0);
    idle(2 * DIV + 8);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 4) == 0, 7'($urandom_range(0, 127)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100_000, clk cycles per digit-scan slot (500 Hz per digit at 100 MHz).
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 value  input  7  unsigned binary count to display (0..99 nominal).
REQ-005 value_valid  input  1  one-cycle load strobe for value.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 overrange  output  1  high while the displayed value exceeds 99.
REQ-008 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-009 an  output  2  active-low digit enables; an[0] = ones, an[1] = tens.

Function
REQ-010 FSM states IDLE, CONVERT, DONE; the block SHALL leave IDLE only on value_valid=1 sampled in IDLE.
REQ-011 IDLE + value_valid SHALL load a 15-bit shift register {8'h00, value}, clear the iteration count, set busy, and enter CONVERT.
REQ-012 Each CONVERT cycle SHALL add 3 to every BCD nibble >= 5, then shift left by one bit; exactly 7 iterations, then DONE.
REQ-013 DONE SHALL commit tens/ones to the display registers, clear busy, and return to IDLE; the sampling edge plus 8 edges gives a fixed latency, with busy high for 8 cycles.
REQ-014 value_valid while busy SHALL be ignored; there is no queueing.
REQ-015 A captured value >= 100 SHALL still run the full sequence; at commit, overrange=1 and both digits show dash (seg=7'b0111111).
REQ-016 A captured value <= 99 SHALL clear overrange at commit.
REQ-017 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at the wrap it SHALL toggle the active digit.
REQ-018 Exactly one an bit SHALL be low at any time; seg SHALL be the registered decode of the active digit (0-9 standard patterns).
REQ-019 The scan SHALL run continuously and independently of the converter; the display registers change only in DONE.

Reset
REQ-020 reset low SHALL force state IDLE, busy=0, overrange=0, tens=0, ones=0, refresh counter=0, active digit=ones.
REQ-021 Outputs during and after reset: an=2'b10, seg=7'b1000000 ("0").
REQ-022 Reset mid-conversion SHALL abort without committing; the digits read 00.

Configuration
REQ-023 Macro SEG_DISPLAY_LEADING_ZERO_BLANK_EN defined: when tens=0 and overrange=0, the tens slot SHALL drive seg=7'b1111111 (blank) while an[1] is still scanned.
REQ-024 Macro not defined: the tens slot SHALL always show its digit, including "0".

Structure
REQ-025 Package seg_display_pkg SHALL hold the FSM state typedef, the SEG_BLANK and SEG_DASH constants, and the 0-9 segment pattern constants.
REQ-026 Sub-module bin2bcd_seq SHALL contain the CONVERT/DONE double-dabble FSM (value/value_valid in; tens, ones, busy, done out); the top level holds the display registers, the scan logic, and the decode.

Verification
REQ-027 Release reset, no strobe -> an alternates 10/01 every REFRESH_DIV cycles; seg=7'b1000000 in both slots (macro off).
REQ-028 value=7'd57 strobe -> busy high exactly 8 cycles; then tens=5 (seg 7'b0010010), ones=7 (seg 7'b1111000).
REQ-029 value=7'd99, then a second strobe value=7'd10 two cycles later -> the second strobe is ignored; the display shows 99.
REQ-030 value=7'd120 -> overrange=1, both slots 7'b0111111; then value=7'd3 -> overrange=0, digits 03.
REQ-031 value=7'd42 strobe, reset asserted on cycle 4 of busy -> busy=0, digits 00, an=2'b10.
REQ-032 Macro on, value=7'd7 -> tens slot 7'b1111111, ones slot 7'b1111000; value=7'd0 -> tens blank, ones "0".
